// File: rtl/controlador_llenado.sv
// -----------------------------------------------------------------------------
// controlador_llenado
// Fill and replacement controller for a 4-way set-associative cache.
// Accepts one miss at a time and tracks per-set valid bits and round-robin
// victim pointers. It picks the lowest free way, or the pointer way with an
// eviction flag when the set is full. It then runs the memory req/ack
// handshake and issues a one-cycle fill command.
//
// Optional feature macro: FILL_TIMEOUT_EN
//   When defined, a 4-bit counter bounds the REQ wait to TIMEOUT cycles.
//   On expiry err pulses for one cycle and the FSM returns to IDLE with no
//   fill. When undefined, REQ waits indefinitely and err is tied 0.
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   miss_valid/miss_set  miss request in; miss_ready high in IDLE only
//   inv_valid/inv_set/inv_way  invalidate strobe, applied in any state
//   mem_req/mem_set      memory line request; mem_ack completes it
//   fill_valid/fill_set/fill_way/fill_evict  one-cycle fill command
//   busy                 FSM not in IDLE
//   err                  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module controlador_llenado #(
    parameter int SETS    = 4,
    parameter int SW      = 2,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          miss_valid,
    input  logic [SW-1:0] miss_set,
    output logic          miss_ready,
    input  logic          inv_valid,
    input  logic [SW-1:0] inv_set,
    input  logic [1:0]    inv_way,
    output logic          mem_req,
    output logic [SW-1:0] mem_set,
    input  logic          mem_ack,
    output logic          fill_valid,
    output logic [SW-1:0] fill_set,
    output logic [1:0]    fill_way,
    output logic          fill_evict,
    output logic          busy,
    output logic          err
);

    // The timeout counter is 4 bits wide, so TIMEOUT must fit in 1..16.
    if (TIMEOUT < 1 || TIMEOUT > 16) begin : g_bad_timeout
        $error("controlador_llenado: TIMEOUT must be in 1..16");
    end

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] set_q, set_d;
    logic [1:0]    way_q, way_d;
    logic          evict_q, evict_d;
    logic [3:0]    valid_q [SETS];
    logic [3:0]    valid_d [SETS];
    logic [1:0]    ptr_q   [SETS];
    logic [1:0]    ptr_d   [SETS];
`ifdef FILL_TIMEOUT_EN
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Free ways of the requesting set, taken from the pre-invalidate state.
    logic [3:0] free_vec;
    assign free_vec = ~valid_q[miss_set];

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        evict_d = evict_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef FILL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        // Invalidate is applied first so a same-cycle fill below overrides it.
        if (inv_valid) begin
            valid_d[inv_set][inv_way] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    set_d = miss_set;
                    if (free_vec != 4'b0000) begin
                        evict_d = 1'b0;
                        if      (free_vec[0]) way_d = 2'd0;
                        else if (free_vec[1]) way_d = 2'd1;
                        else if (free_vec[2]) way_d = 2'd2;
                        else                  way_d = 2'd3;
                    end else begin
                        evict_d          = 1'b1;
                        way_d            = ptr_q[miss_set];
                        ptr_d[miss_set]  = ptr_q[miss_set] + 2'd1;
                    end
                    state_d = REQ;
`ifdef FILL_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = FILL;
`ifdef FILL_TIMEOUT_EN
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    // Give up: no fill, no valid update; ptr advance is kept.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
`endif
                end
            end
            FILL: begin
                valid_d[set_q][way_q] = 1'b1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: valid/ptr arrays are reset explicitly because replacement decisions
    // read them right after reset; they are small flop arrays, not RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            evict_q <= 1'b0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= '0;
                ptr_q[i]   <= '0;
            end
`ifdef FILL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            evict_q <= evict_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef FILL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decoded from the state register, so reset drops them at once.
    assign miss_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_req    = (state_q == REQ);
    assign mem_set    = set_q;
    assign fill_valid = (state_q == FILL);
    assign fill_set   = set_q;
    assign fill_way   = way_q;
    assign fill_evict = (state_q == FILL) && evict_q;
`ifdef FILL_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_llenado.sv
// -----------------------------------------------------------------------------
// tb_controlador_llenado
// Directed stimulus with a scoreboard: each miss pushes its expected fill
// {set, way, evict}; an independent monitor pops and compares on fill_valid.
// -----------------------------------------------------------------------------
module tb_controlador_llenado;

    logic       clk = 1'b0;
    logic       reset;
    logic       miss_valid;
    logic [1:0] miss_set;
    logic       miss_ready;
    logic       inv_valid;
    logic [1:0] inv_set;
    logic [1:0] inv_way;
    logic       mem_req;
    logic [1:0] mem_set;
    logic       mem_ack;
    logic       fill_valid;
    logic [1:0] fill_set;
    logic [1:0] fill_way;
    logic       fill_evict;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected fill: {set[1:0], way[1:0], evict}
    logic [4:0] exp_q [$];

    controlador_llenado #(.SETS(4), .SW(2), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .miss_valid (miss_valid),
        .miss_set   (miss_set),
        .miss_ready (miss_ready),
        .inv_valid  (inv_valid),
        .inv_set    (inv_set),
        .inv_way    (inv_way),
        .mem_req    (mem_req),
        .mem_set    (mem_set),
        .mem_ack    (mem_ack),
        .fill_valid (fill_valid),
        .fill_set   (fill_set),
        .fill_way   (fill_way),
        .fill_evict (fill_evict),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compares every fill command against the scoreboard.
    always @(negedge clk) begin
        if (fill_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("fill_unexpected", 1, 0);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("fill_cmd", {27'd0, fill_set, fill_way, fill_evict}, {27'd0, e});
            end
        end
    end

    // Issue one miss starting at #1 after an edge in IDLE; ack after d REQ cycles.
    task automatic do_miss(input logic [1:0] s, input int d, input logic [1:0] w,
                           input logic e, input bit inv_in_fill,
                           input logic [1:0] is, input logic [1:0] iw);
        check("ready_before_miss", miss_ready, 1);
        miss_valid = 1'b1;
        miss_set   = s;
        exp_q.push_back({s, w, e});
        @(posedge clk); #1;
        miss_valid = 1'b0;
        check("req_n1", mem_req, 1);
        check("req_set", mem_set, s);
        check("busy_req", busy, 1);
        check("ready_req", miss_ready, 0);
        for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            check("req_hold", {mem_req, mem_set}, {1'b1, s});
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("fill_n2", fill_valid, 1);
        check("req_drop", mem_req, 0);
        if (inv_in_fill) begin
            inv_valid = 1'b1;
            inv_set   = is;
            inv_way   = iw;
        end
        @(posedge clk); #1;
        inv_valid = 1'b0;
        check("ready_n3", miss_ready, 1);
        check("fill_one_cycle", fill_valid, 0);
    endtask

    task automatic do_inv(input logic [1:0] s, input logic [1:0] w);
        inv_valid = 1'b1;
        inv_set   = s;
        inv_way   = w;
        @(posedge clk); #1;
        inv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        miss_valid = 1'b0; miss_set = '0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_miss_ready", miss_ready, 1);
        check("rst_ctrl", {mem_req, fill_valid, fill_evict, busy, err}, 5'b0);
        check("rst_data", {mem_set, fill_set, fill_way}, 6'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Set 2: first fill goes to way 0, then way 1 (valid[2] was 0001).
        do_miss(2'd2, 0, 2'd0, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd2, 2, 2'd1, 1'b0, 0, 2'd0, 2'd0);

        // mem_ack in IDLE is ignored.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("ack_idle_ignored", busy, 0);

        // Set 1: fill all four ways, then round-robin victims 0 and 1.
        for (int i = 0; i < 4; i++) do_miss(2'd1, 0, 2'(i), 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd1, 0, 2'd0, 1'b1, 0, 2'd0, 2'd0);
        do_miss(2'd1, 1, 2'd1, 1'b1, 0, 2'd0, 2'd0);

        // Set 3: full, invalidate way 2, refill it; ptr[3] still 0 afterwards.
        for (int i = 0; i < 4; i++) do_miss(2'd3, 0, 2'(i), 1'b0, 0, 2'd0, 2'd0);
        do_inv(2'd3, 2'd2);
        do_miss(2'd3, 0, 2'd2, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd3, 0, 2'd0, 1'b1, 0, 2'd0, 2'd0);

        // Set 0: invalidate way 1 during its own fill; the fill wins.
        do_miss(2'd0, 0, 2'd0, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd0, 0, 2'd1, 1'b0, 1, 2'd0, 2'd1);
        do_miss(2'd0, 0, 2'd2, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd0, 0, 2'd3, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd0, 0, 2'd0, 1'b1, 0, 2'd0, 2'd0);

        // Same-cycle invalidate and selection on set 0 (full): selection sees
        // the pre-invalidate state, so it evicts ptr way 1; way 3 is freed.
        inv_valid = 1'b1; inv_set = 2'd0; inv_way = 2'd3;
        do_miss(2'd0, 0, 2'd1, 1'b1, 0, 2'd0, 2'd0);
        do_miss(2'd0, 0, 2'd3, 1'b0, 0, 2'd0, 2'd0);

        // Reset in the middle of REQ: mem_req drops without a clock edge.
        miss_valid = 1'b1;
        miss_set   = 2'd1;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("req_before_rst", mem_req, 1);
        reset = 1'b1;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_fill", fill_valid, 0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("no_fill_after_rst", {fill_valid, busy}, 2'b00);
        // All valid cleared: sets 1 and 2 start over at way 0.
        do_miss(2'd1, 0, 2'd0, 1'b0, 0, 2'd0, 2'd0);
        do_miss(2'd2, 0, 2'd0, 1'b0, 0, 2'd0, 2'd0);

`ifdef FILL_TIMEOUT_EN
        // No mem_ack: 15 REQ cycles, then one err pulse and back to IDLE.
        miss_valid = 1'b1;
        miss_set   = 2'd2;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("tmo_still_req", {mem_req, err}, 2'b10);
        @(posedge clk); #1;
        check("tmo_err", err, 1);
        check("tmo_ready", {miss_ready, busy, mem_req}, 3'b100);
        @(posedge clk); #1;
        check("tmo_err_pulse", err, 0);
        // No valid update: set 2 next fills way 1.
        do_miss(2'd2, 0, 2'd1, 1'b0, 0, 2'd0, 2'd0);
`endif

        check("err_idle", err, 0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_llenado.md
# controlador_llenado

Fill and replacement controller for the 4-way set-associative cache. It accepts one miss request at a time and tracks the valid bits of every set. It picks the destination way as either the lowest free way or, if the set is full, a round-robin victim with an eviction flag. It then runs the memory request/acknowledge handshake and issues a single-cycle fill command to the data and tag arrays.

## Interface
Parameters:
- `SETS`, 4, number of cache sets (power of two, ≥2).
- `SW`, 2, set-index width, log2(`SETS`).
- `TIMEOUT`, 15, cycles allowed for `mem_ack` (used only with `FILL_TIMEOUT_EN`).

Ports:
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `miss_valid` in 1: a miss request is present.
- `miss_set` in `SW`: set index of the miss.
- `miss_ready` out 1: controller is able to accept a miss.
- `inv_valid` in 1: invalidate strobe.
- `inv_set` in `SW`: set index to invalidate.
- `inv_way` in 2: way index to invalidate.
- `mem_req` out 1: line request to memory.
- `mem_set` out `SW`: set index of the outstanding request.
- `mem_ack` in 1: memory data is available.
- `fill_valid` out 1: one-cycle fill command.
- `fill_set` out `SW`: set index of the fill.
- `fill_way` out 2: way index of the fill.
- `fill_evict` out 1: the fill overwrites a valid line.
- `busy` out 1: FSM is not in IDLE.
- `err` out 1: one-cycle timeout pulse (tied 0 without `FILL_TIMEOUT_EN`).

## Operation
- Per-set state:
  - `valid[s][3:0]`.
  - `ptr[s][1:0]`, the round-robin victim pointer.
- Free vector of a set: `C = ~valid[s]`.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - `miss_ready` = 1.
  - On `miss_valid`, latch `miss_set` and select the way:
    - If `C` ≠ 0: way = lowest index with `C[i]` = 1, evict = 0.
    - If `C` = 0: way = `ptr[s]`, evict = 1, and `ptr[s]` increments modulo 4 in the same cycle.
  - Go to REQ.
- REQ:
  - `mem_req` = 1 and `mem_set` = latched set, held steady until `mem_ack`.
  - On `mem_ack`, go to FILL.
- FILL:
  - `fill_valid` = 1 for exactly one cycle with the latched set, way and evict.
  - Set `valid[set][way]` = 1, then return to IDLE.
- Invalidate:
  - Accepted in any state and applied in the same cycle: `valid[inv_set][inv_way]` = 0.
  - Does not change the way already latched for an in-flight miss.
- Simultaneous invalidate and fill to the same set/way: the fill wins, and the bit ends at 1.
- Simultaneous invalidate and way selection in IDLE on the same set: selection uses the pre-invalidate `valid`.
- `ptr` does not change on invalidate or on fills into free ways.

## Timing
- Reset values:
  - `miss_ready` = 1.
  - `mem_req`, `fill_valid`, `fill_evict`, `busy`, `err` = 0.
  - `mem_set`, `fill_set`, `fill_way` = 0.
  - All `valid` and `ptr` = 0.
  - FSM = IDLE.
- All outputs are registered or decoded from the FSM state.
- `miss_ready` is combinational from state (IDLE only).
- Latency with `mem_ack` arriving in the first REQ cycle:
  - accept at edge N;
  - `mem_req` high in cycle N+1;
  - `fill_valid` in cycle N+2;
  - `miss_ready` high again in cycle N+3.
- Back-to-back misses have a minimum 3-cycle spacing.
- `mem_ack` outside REQ is ignored.
- Reset asserted mid-transaction drops `mem_req`/`fill_valid` immediately (asynchronously). No fill is issued.

## Configuration
- `FILL_TIMEOUT_EN` defined:
  - A 4-bit counter runs in REQ.
  - If `TIMEOUT` cycles pass without `mem_ack`, `err` pulses for one cycle, the FSM returns to IDLE, and no fill or valid update occurs.
  - A `ptr` increment already applied is kept.
- `FILL_TIMEOUT_EN` undefined: no counter exists, REQ waits indefinitely, and `err` = 0.

## Test plan
- Reset, then a miss to set 2 with `mem_ack` in the first REQ cycle → `fill_valid` at N+2 with set 2, way 0, `fill_evict` = 0; `valid[2]` becomes 4'b0001.
- Four misses to set 1, then a fifth → ways 0,1,2,3 with evict 0; fifth gives way 0 with evict 1; a sixth gives way 1 with evict 1.
- Set 3 full, invalidate way 2, then a miss → way 2, evict 0, and `ptr[3]` unchanged.
- Invalidate set0/way1 in the same cycle as a fill to set0/way1 → `valid[0][1]` = 1.
- `mem_ack` delayed 5 cycles, then `reset` asserted in REQ → `mem_req` drops without waiting for a clock edge, no `fill_valid`, all `valid` = 0.
- `FILL_TIMEOUT_EN` with `TIMEOUT` = 15 and no `mem_ack` → `err` pulses once, no fill, `miss_ready` = 1 the next cycle.
